// File: rtl/mpe_ctrl.sv
// Sequencer for the matrix PE: walks the rows of a weight matrix, issues one
// micro-op per row, fetches paired NRAM/WRAM beats, and writes each row result.
module mpe_ctrl #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_n_out,
  input  logic [7:0]    cmd_n_iter,
  input  logic [AW-1:0] cmd_nram_base,
  input  logic [AW-1:0] cmd_wram_base,
  input  logic [AW-1:0] cmd_out_base,
  output logic          rd_req_valid,
  input  logic          rd_req_ready,
  output logic [AW-1:0] rd_nram_addr,
  output logic [AW-1:0] rd_wram_addr,
  output logic          uop_valid,
  input  logic          uop_ready,
  output logic [7:0]    uop,
  input  logic          pe_vld,
  input  logic [31:0]   pe_result,
  output logic          out_wr_en,
  output logic [AW-1:0] out_wr_addr,
  output logic [31:0]   out_wr_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_UOP   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]    state;
  logic [7:0]    n_out;
  logic [7:0]    n_iter;
  logic [AW-1:0] nram_base;
  logic [AW-1:0] wram_base;
  logic [AW-1:0] out_base;
  logic [7:0]    i;
  logic [7:0]    j;
  logic [AW-1:0] row_ofs;

  // Row offset is formed at 16 bits and only then folded into the address space.
  assign row_ofs = AW'(16'(j) * 16'(n_iter));

  // NOTE: handshake outputs decode the registered state only, so valid never
  // depends combinationally on the matching ready.
  assign cmd_ready    = (state == S_IDLE);
  assign uop_valid    = (state == S_UOP);
  assign rd_req_valid = (state == S_FETCH);
  assign done         = (state == S_FIN);
  assign busy         = (state != S_IDLE);
  assign uop          = n_iter;
  assign rd_nram_addr = nram_base + AW'(i);
  assign rd_wram_addr = wram_base + row_ofs + AW'(i);

  // NOTE: reset is synchronous and clears every register, including latched
  // command fields, so a reset mid-command leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      n_out       <= '0;
      n_iter      <= '0;
      nram_base   <= '0;
      wram_base   <= '0;
      out_base    <= '0;
      i           <= '0;
      j           <= '0;
      err         <= 1'b0;
      out_wr_en   <= 1'b0;
      out_wr_addr <= '0;
      out_wr_data <= '0;
    end else begin
      out_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            n_out     <= cmd_n_out;
            n_iter    <= cmd_n_iter;
            nram_base <= cmd_nram_base;
            wram_base <= cmd_wram_base;
            out_base  <= cmd_out_base;
            i         <= '0;
            j         <= '0;
            err       <= 1'b0;
            state     <= (cmd_n_out == 8'd0 || cmd_n_iter == 8'd0) ? S_FIN : S_UOP;
          end
        end
        S_UOP: begin
          if (uop_ready) state <= S_FETCH;
        end
        S_FETCH: begin
          if (rd_req_ready) begin
            if (i == n_iter - 8'd1) begin
              i     <= '0;
              state <= S_WAIT;
            end else begin
              i <= i + 8'd1;
            end
          end
        end
        S_WAIT: begin
          if (pe_vld) begin
            out_wr_en   <= 1'b1;
            out_wr_addr <= out_base + AW'(j);
            out_wr_data <= pe_result;
            if (j == n_out - 8'd1) begin
              state <= S_FIN;
            end else begin
              j     <= j + 8'd1;
              state <= S_UOP;
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // A strobe outside WAIT has no row to belong to; flag it, and let it win
      // over the clear of a same-cycle command acceptance.
      if (pe_vld && state != S_WAIT) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mpe_ctrl.sv
// Scoreboard bench for mpe_ctrl: a reference model fills expectation queues
// per command; a monitor pops and compares on every DUT transfer.
module tb_mpe_ctrl;
  localparam int AW   = 12;
  localparam int AMOD = 1 << AW;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_n_out;
  logic [7:0]    cmd_n_iter;
  logic [AW-1:0] cmd_nram_base;
  logic [AW-1:0] cmd_wram_base;
  logic [AW-1:0] cmd_out_base;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_nram_addr;
  logic [AW-1:0] rd_wram_addr;
  logic          uop_valid;
  logic          uop_ready;
  logic [7:0]    uop;
  logic          pe_vld;
  logic [31:0]   pe_result;
  logic          out_wr_en;
  logic [AW-1:0] out_wr_addr;
  logic [31:0]   out_wr_data;
  logic          busy;
  logic          done;
  logic          err;

  mpe_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_n_out(cmd_n_out), .cmd_n_iter(cmd_n_iter),
    .cmd_nram_base(cmd_nram_base), .cmd_wram_base(cmd_wram_base),
    .cmd_out_base(cmd_out_base),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_nram_addr(rd_nram_addr), .rd_wram_addr(rd_wram_addr),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop(uop),
    .pe_vld(pe_vld), .pe_result(pe_result),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expectation queues (scoreboard)
  logic [7:0]        exp_uop[$];
  logic [2*AW-1:0]   exp_rd[$];
  logic [AW+31:0]    exp_wr[$];
  bit                exp_done[$];
  logic [31:0]       fixed_res[$];

  // Current command context shared with the stimulus drivers
  int            cur_n_iter = 0;
  logic [AW-1:0] cur_out_base = '0;
  int            cmd_seq = 0;
  int            stray_seq = 0;
  int            rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: every row gets one uop, then n_iter paired beats.
  task automatic push_model(input int no, input int ni, input int nb, input int wb);
    logic [AW-1:0] na;
    logic [AW-1:0] wa;
    exp_done.push_back(1'b1);
    if (no == 0 || ni == 0) return;
    for (int r = 0; r < no; r++) begin
      exp_uop.push_back(8'(ni));
      for (int b = 0; b < ni; b++) begin
        na = AW'((nb + b) % AMOD);
        wa = AW'((wb + ((r * ni) % 65536) % AMOD + b) % AMOD);
        exp_rd.push_back({na, wa});
      end
    end
  endtask

  // PE model: answers one result a few cycles after the last beat of a row.
  initial begin : pe_drv
    int beat;
    int row;
    int countdown;
    int seq;
    int sseq;
    logic [AW-1:0] wa;
    beat = 0; row = 0; countdown = 0; seq = 0; sseq = 0;
    pe_vld = 1'b0;
    pe_result = '0;
    forever begin
      @(negedge clk);
      if (rst || seq != cmd_seq) begin
        beat = 0; row = 0; countdown = 0; seq = cmd_seq;
      end else if (rd_req_valid && rd_req_ready) begin
        beat++;
        if (beat == cur_n_iter) begin
          beat = 0;
          countdown = $urandom_range(1, 3);
        end
      end
      @(posedge clk);
      #1;
      pe_vld = 1'b0;
      if (sseq != stray_seq) begin
        sseq = stray_seq;
        pe_vld = 1'b1;
        pe_result = $urandom;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          pe_result = (fixed_res.size() != 0) ? fixed_res.pop_front() : $urandom;
          pe_vld = 1'b1;
          wa = cur_out_base + AW'(row);
          exp_wr.push_back({wa, pe_result});
          row++;
        end
      end
    end
  end

  // Ready driver: mode 0 always ready, 1 random, 2 directed stalls
  // (beat 1 held 4 cycles, first uop held 3 cycles).
  initial begin : rdy_drv
    int rd_hold;
    int u_hold;
    int seq;
    bit armed;
    rd_hold = 0; u_hold = 0; seq = 0; armed = 1'b0;
    rd_req_ready = 1'b1;
    uop_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst || seq != cmd_seq) begin
        rd_hold = 0; u_hold = 0; armed = 1'b0; seq = cmd_seq;
      end else if (rd_req_valid && rd_req_ready && rdy_mode == 2) begin
        armed = 1'b1;
      end
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          rd_req_ready = ($urandom_range(0, 2) != 0);
          uop_ready    = ($urandom_range(0, 2) != 0);
        end
        2: begin
          if (armed && rd_hold < 4) begin
            rd_req_ready = 1'b0;
            rd_hold++;
          end else begin
            rd_req_ready = 1'b1;
          end
          if (uop_valid && u_hold < 3) begin
            uop_ready = 1'b0;
            u_hold++;
          end else begin
            uop_ready = 1'b1;
          end
        end
        default: begin
          rd_req_ready = 1'b1;
          uop_ready    = 1'b1;
        end
      endcase
    end
  end

  // Monitor: compares each transfer against the queues and checks stall stability.
  initial begin : monitor
    bit            rd_st;
    bit            u_st;
    logic [AW-1:0] pn;
    logic [AW-1:0] pw;
    logic [7:0]    pu;
    rd_st = 1'b0; u_st = 1'b0; pn = '0; pw = '0; pu = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_st = 1'b0;
        u_st  = 1'b0;
      end else begin
        if (rd_st) begin
          check("rd_stall_valid", 32'(rd_req_valid), 32'd1);
          check("rd_stall_addr", 32'({rd_nram_addr, rd_wram_addr}), 32'({pn, pw}));
        end
        if (u_st) begin
          check("uop_stall_valid", 32'(uop_valid), 32'd1);
          check("uop_stall_value", 32'(uop), 32'(pu));
        end
        if (uop_valid && uop_ready) begin
          check("uop_expected", 32'(exp_uop.size() != 0), 32'd1);
          if (exp_uop.size() != 0) check("uop_value", 32'(uop), 32'(exp_uop.pop_front()));
        end
        if (rd_req_valid && rd_req_ready) begin
          check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
          if (exp_rd.size() != 0)
            check("rd_addrs", 32'({rd_nram_addr, rd_wram_addr}), 32'(exp_rd.pop_front()));
        end
        if (out_wr_en) begin
          check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
          if (exp_wr.size() != 0) begin
            logic [AW+31:0] e;
            e = exp_wr.pop_front();
            check("wr_addr", 32'(out_wr_addr), 32'(e[AW+31:32]));
            check("wr_data", out_wr_data, e[31:0]);
          end
        end
        if (done) begin
          check("done_expected", 32'(exp_done.size() != 0), 32'd1);
          if (exp_done.size() != 0) void'(exp_done.pop_front());
        end
        rd_st = rd_req_valid && !rd_req_ready;
        pn = rd_nram_addr;
        pw = rd_wram_addr;
        u_st = uop_valid && !uop_ready;
        pu = uop;
      end
    end
  end

  task automatic issue(input int no, input int ni, input logic [AW-1:0] nb,
                       input logic [AW-1:0] wb, input logic [AW-1:0] ob);
    int t;
    @(posedge clk);
    #1;
    cmd_n_out     = 8'(no);
    cmd_n_iter    = 8'(ni);
    cmd_nram_base = nb;
    cmd_wram_base = wb;
    cmd_out_base  = ob;
    cmd_valid     = 1'b1;
    cur_n_iter    = ni;
    cur_out_base  = ob;
    cmd_seq++;
    push_model(no, ni, int'(nb), int'(wb));
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_done.size() != 0 && t < 3000) begin
      @(negedge clk);
      #2;
      t++;
    end
    check("done_timeout", 32'(exp_done.size() == 0), 32'd1);
    check("leftover_items", 32'(exp_uop.size() + exp_rd.size() + exp_wr.size()), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outs();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rd_req_valid", 32'(rd_req_valid), 32'd0);
    check("rst_uop_valid", 32'(uop_valid), 32'd0);
    check("rst_uop", 32'(uop), 32'd0);
    check("rst_out_wr_en", 32'(out_wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
  endtask

  initial begin : main
    int t;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_n_out = '0;
    cmd_n_iter = '0;
    cmd_nram_base = '0;
    cmd_wram_base = '0;
    cmd_out_base = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic command with fixed PE results
    fixed_res.push_back(32'hA);
    fixed_res.push_back(32'hB);
    issue(2, 3, 12'h010, 12'h100, 12'h200);
    wait_done();

    // Directed back-pressure on beat 1 and the first uop
    rdy_mode = 2;
    issue(2, 4, 12'h020, 12'h300, 12'h040);
    wait_done();
    rdy_mode = 0;

    // Zero commands finish one cycle after acceptance
    issue(0, 5, 12'h001, 12'h002, 12'h003);
    @(negedge clk);
    check("zero_done_pulse", 32'(done), 32'd1);
    wait_done();
    issue(3, 0, 12'h001, 12'h002, 12'h003);
    @(negedge clk);
    check("zero_iter_done_pulse", 32'(done), 32'd1);
    wait_done();

    // Address wrap, then a stray strobe in IDLE
    issue(2, 4, 12'h7F0, 12'hFFE, 12'hFFF);
    wait_done();
    @(posedge clk);
    #1;
    stray_seq++;
    repeat (3) @(negedge clk);
    check("stray_err_set", 32'(err), 32'd1);
    check("stray_err_still_idle", 32'(busy), 32'd0);
    issue(1, 1, 12'h000, 12'h000, 12'h010);
    @(negedge clk);
    check("err_clear_on_accept", 32'(err), 32'd0);
    wait_done();

    // Reset in the middle of FETCH abandons the command
    issue(3, 6, 12'h100, 12'h200, 12'h300);
    t = 0;
    @(negedge clk);
    while (!rd_req_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("fetch_reached", 32'(rd_req_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_uop.delete();
    exp_rd.delete();
    exp_wr.delete();
    exp_done.delete();
    fixed_res.delete();
    @(negedge clk);
    check_reset_outs();
    repeat (6) @(negedge clk);
    issue(2, 3, 12'h050, 12'h060, 12'h070);
    wait_done();

    // Randomized commands under random back-pressure
    rdy_mode = 1;
    for (int k = 0; k < 20; k++) begin
      issue($urandom_range(0, 4), $urandom_range(0, 6),
            AW'($urandom), AW'($urandom), AW'($urandom));
      wait_done();
    end
    rdy_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mpe_ctrl.md
MPE_CTRL -- requirements
Module: mpe_ctrl

Interface
REQ-001 Parameter AW, default 12, RAM address width for NRAM, WRAM and the output buffer.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-005 cmd_n_out  input  8  number of output results (matrix rows).
REQ-006 cmd_n_iter  input  8  512-bit beats accumulated per result.
REQ-007 cmd_nram_base, cmd_wram_base, cmd_out_base  input  AW each  base addresses for neuron vector, weight matrix and results.
REQ-008 rd_req_valid / rd_req_ready  output / input  1 / 1  fetch request handshake to the NRAM/WRAM read unit.
REQ-009 rd_nram_addr, rd_wram_addr  output  AW each  paired beat addresses, valid with rd_req_valid.
REQ-010 uop_valid / uop_ready  output / input  1 / 1  micro-op handshake to the matrix PE.
REQ-011 uop  output  8  iteration count for one result; equals latched n_iter.
REQ-012 pe_vld  input  1  one-cycle result strobe from the matrix PE.
REQ-013 pe_result  input  32  PE result, sampled when pe_vld=1.
REQ-014 out_wr_en, out_wr_addr, out_wr_data  output  1, AW, 32  result write port; no back-pressure.
REQ-015 busy, done, err  output  1 each  status flags.

Function
REQ-016 States: IDLE, UOP, FETCH, WAIT, FIN; the FSM is in exactly one state.
REQ-017 IDLE: cmd_ready=1; on cmd_valid&cmd_ready, latch all cmd fields and clear row index j and beat index i.
REQ-018 Command with n_out=0 or n_iter=0 -> FIN directly; no requests, uops or writes are issued.
REQ-019 Otherwise IDLE -> UOP; uop_valid=1 first in the cycle after acceptance.
REQ-020 UOP: uop_valid=1, uop=n_iter, held stable until uop_ready; on transfer -> FETCH.
REQ-021 FETCH: rd_req_valid=1, rd_nram_addr=nram_base+i, rd_wram_addr=wram_base+j*n_iter+i; all sums truncate modulo 2^AW.
REQ-022 Addresses are held stable while rd_req_valid=1 and rd_req_ready=0; valid does not depend combinationally on ready.
REQ-023 Each rd_req transfer increments i; the transfer with i=n_iter-1 clears i and moves to WAIT with rd_req_valid=0 on the next cycle.
REQ-024 WAIT: on pe_vld, drive out_wr_en=1 for exactly one cycle on the next edge with out_wr_addr=out_base+j and out_wr_data=pe_result.
REQ-025 WAIT on pe_vld: if j=n_out-1 -> FIN, else j<=j+1 -> UOP.
REQ-026 At most one uop is outstanding; no uop is issued for row j+1 before the result of row j is received.
REQ-027 FIN: done=1 for exactly one cycle, then IDLE.
REQ-028 busy=1 in every state except IDLE.
REQ-029 cmd_ready=0 outside IDLE; cmd_valid outside IDLE is ignored and not queued.
REQ-030 pe_vld outside WAIT: no write is issued, and err is set.
REQ-031 err is sticky and is cleared only by reset or by the next command acceptance.
REQ-032 j*n_iter is computed at 16 bits, then truncated to AW before the add.

Reset
REQ-033 rst=1 at a rising edge forces the FSM to IDLE.
REQ-034 Under reset, all counters and latched fields are cleared.
REQ-035 Under reset, outputs are cmd_ready=1, rd_req_valid=0, uop_valid=0, out_wr_en=0, busy=0, done=0, err=0.
REQ-036 Reset mid-command abandons the command with no done pulse and no further writes.
REQ-037 Reset takes effect from the cycle after the reset edge.

Verification
REQ-038 Basic command: n_out=2, n_iter=3, nram_base=0x010, wram_base=0x100, out_base=0x200, readies=1.
  -> uops 3,3
  -> NRAM addrs 010,011,012 twice
  -> WRAM addrs 100..105
  -> pe_vld with 0xA then 0xB gives writes 0x200=0xA and 0x201=0xB
  -> done pulses once.
REQ-039 Back-pressure: hold rd_req_ready=0 for 4 cycles on beat 1 and uop_ready=0 for 3 cycles.
  -> address and uop outputs stay stable while stalled
  -> no beat is lost or duplicated.
REQ-040 Zero command: n_out=0, n_iter=5.
  -> done pulses 1 cycle after acceptance
  -> no rd_req, uop or write is issued.
REQ-041 Wrap and stray strobe: wram_base=0xFFE, n_iter=4, j=1.
  -> addrs wrap to 0x002..0x005
  -> pe_vld in IDLE sets err, and err clears at the next acceptance.
REQ-042 Reset mid-FETCH: assert rst during FETCH, then issue a new command.
  -> reset values from the next cycle
  -> no done pulse
  -> the new command runs from j=0, i=0.
